// File: rtl/dual_issue_hazard_scoreboard.sv
// Issue-side hazard scoreboard for a dual-issue pipeline: per-register pending counters
// plus intra-pair RAW detection decide whether the ID pair dispatches, splits or holds.
module dual_issue_hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid1,
  input  logic              id_valid2,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rt1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rt2_id,
  input  logic              use_rs1,
  input  logic              use_rt1,
  input  logic              use_rs2,
  input  logic              use_rt2,
  input  logic [4:0]        dest1_id,
  input  logic [4:0]        dest2_id,
  input  logic              regwrite1_id,
  input  logic              regwrite2_id,
  input  logic              memread1_id,
  input  logic              memread2_id,
  output logic              issue1,
  output logic              issue2,
  output logic              hold_id,
  output logic              split_active,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [0:0]        ST_PAIR  = 1'b0;
  localparam logic [0:0]        ST_SOLO2 = 1'b1;
  localparam logic [CNT_W-1:0]  LOAD_SET = CNT_W'(LOAD_LAT);
  localparam logic [PERF_W-1:0] STALL_MAX = {PERF_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              issue1_s, issue2_s, hold_s;
  logic              hz1_s, sb2_s, intra_s;

  // Register 0 is hardwired, so it can never be a pending source.
  function automatic logic src_busy(input logic use_src, input logic [4:0] r,
                                    input logic [CNT_W-1:0] cnt);
    return use_src && (r != 5'd0) && (cnt != {CNT_W{1'b0}});
  endfunction

  assign hz1_s   = src_busy(use_rs1, rs1_id, cnt_q[rs1_id]) |
                   src_busy(use_rt1, rt1_id, cnt_q[rt1_id]);
  assign sb2_s   = src_busy(use_rs2, rs2_id, cnt_q[rs2_id]) |
                   src_busy(use_rt2, rt2_id, cnt_q[rt2_id]);
  assign intra_s = regwrite1_id && (dest1_id != 5'd0) &&
                   ((use_rs2 && (rs2_id == dest1_id)) || (use_rt2 && (rt2_id == dest1_id)));

  // Issue/hold decision and next control state.
  always_comb begin
    issue1_s = 1'b0;
    issue2_s = 1'b0;
    hold_s   = 1'b0;
    state_d  = state_q;
    if (!rst) begin
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR: begin
          if (flush || !id_valid1) begin
            state_d = ST_PAIR;
          end else if (hz1_s) begin
            hold_s = 1'b1;
          end else if (!id_valid2 || (!sb2_s && !intra_s)) begin
            issue1_s = 1'b1;
            issue2_s = id_valid2;
          end else begin
            issue1_s = 1'b1;
            hold_s   = 1'b1;
            state_d  = ST_SOLO2;
          end
        end
        ST_SOLO2: begin
          if (flush) begin
            state_d = ST_PAIR;
          end else if (sb2_s) begin
            hold_s = 1'b1;
          end else begin
            issue2_s = 1'b1;
            state_d  = ST_PAIR;
          end
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  // Counters age by one; a fresh issue overrides, slot2 last so it wins a shared dest.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (cnt_q[i] != {CNT_W{1'b0}}) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end
    if (issue1_s && regwrite1_id && (dest1_id != 5'd0)) begin
      cnt_d[dest1_id] = memread1_id ? LOAD_SET : {CNT_W{1'b0}};
    end else begin
      cnt_d[0] = {CNT_W{1'b0}};
    end
    if (issue2_s && regwrite2_id && (dest2_id != 5'd0)) begin
      cnt_d[dest2_id] = memread2_id ? LOAD_SET : {CNT_W{1'b0}};
    end else begin
      cnt_d[0] = {CNT_W{1'b0}};
    end
  end

  // Saturating stall counter.
  always_comb begin
    if (hold_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + PERF_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State, counter and perf registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_PAIR;
      stall_q <= {PERF_W{1'b0}};
      for (int i = 0; i < 32; i++) cnt_q[i] <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign issue1       = issue1_s;
  assign issue2       = issue2_s;
  assign hold_id      = hold_s;
  assign split_active = rst && (state_q == ST_SOLO2);
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_dual_issue_hazard_scoreboard.sv
// Directed bench for dual_issue_hazard_scoreboard; PERF_W=3 so saturation is reachable.
module tb_dual_issue_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush, id_valid1, id_valid2;
  logic [4:0] rs1_id, rt1_id, rs2_id, rt2_id, dest1_id, dest2_id;
  logic       use_rs1, use_rt1, use_rs2, use_rt2;
  logic       regwrite1_id, regwrite2_id, memread1_id, memread2_id;
  logic       issue1, issue2, hold_id, split_active;
  logic [2:0] stall_count;
  int         vectors = 0;
  int         errors  = 0;

  dual_issue_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(2), .PERF_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid1(id_valid1), .id_valid2(id_valid2),
    .rs1_id(rs1_id), .rt1_id(rt1_id), .rs2_id(rs2_id), .rt2_id(rt2_id),
    .use_rs1(use_rs1), .use_rt1(use_rt1), .use_rs2(use_rs2), .use_rt2(use_rt2),
    .dest1_id(dest1_id), .dest2_id(dest2_id),
    .regwrite1_id(regwrite1_id), .regwrite2_id(regwrite2_id),
    .memread1_id(memread1_id), .memread2_id(memread2_id),
    .issue1(issue1), .issue2(issue2), .hold_id(hold_id),
    .split_active(split_active), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic [2:0] exp);
    vectors++;
    assert (stall_count === exp) else begin
      errors++;
      $error("FAIL %s: observed stall_count %0d expected %0d", tag, stall_count, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic i1, input logic i2,
                       input logic h, input logic s);
    chk_b({tag, ".issue1"}, issue1, i1);
    chk_b({tag, ".issue2"}, issue2, i2);
    chk_b({tag, ".hold_id"}, hold_id, h);
    chk_b({tag, ".split"}, split_active, s);
  endtask

  task automatic set1(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] d, input logic rw, input logic mr);
    id_valid1 = v; rs1_id = rs; use_rs1 = urs; rt1_id = rt; use_rt1 = urt;
    dest1_id = d; regwrite1_id = rw; memread1_id = mr;
  endtask

  task automatic set2(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] d, input logic rw, input logic mr);
    id_valid2 = v; rs2_id = rs; use_rs2 = urs; rt2_id = rt; use_rt2 = urt;
    dest2_id = d; regwrite2_id = rw; memread2_id = mr;
  endtask

  task automatic alu1(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    set1(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b0);
  endtask
  task automatic alu2(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    set2(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b0);
  endtask
  task automatic ld1(input logic [4:0] base, input logic [4:0] d);
    set1(1'b1, base, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1);
  endtask
  task automatic ld2(input logic [4:0] base, input logic [4:0] d);
    set2(1'b1, base, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1);
  endtask
  task automatic none2();
    set2(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    alu1(5'd1, 5'd2, 5'd3); alu2(5'd4, 5'd5, 5'd6);
    @(negedge clk); @(negedge clk); #1;
    chk_o("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_stall("reset", 3'd0);

    @(negedge clk); rst = 1'b1; #1;
    chk_o("indep", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_o("indep_next", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_stall("indep", 3'd0);

    @(negedge clk); flush = 1'b1; alu2(5'd3, 5'd4, 5'd7); #1;
    chk_o("flush_pair", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); flush = 1'b0; set1(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    chk_o("lone_slot2", 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk); alu1(5'd1, 5'd2, 5'd3); alu2(5'd3, 5'd4, 5'd7); #1;
    chk_o("intra_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_o("intra_c1", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_stall("intra", 3'd1);

    @(negedge clk); ld1(5'd1, 5'd8); none2(); #1;
    chk_o("lw8", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); alu1(5'd8, 5'd1, 5'd11); #1;
    chk_o("loaduse_c0", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_o("loaduse_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("loaduse", 3'd2);

    @(negedge clk); ld1(5'd1, 5'd8); #1;
    chk_o("lw8_again", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set1(1'b1, 5'd0, 1'b1, 5'd8, 1'b0, 5'd12, 1'b1, 1'b0); #1;
    chk_o("r0_src", 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk); ld1(5'd1, 5'd9); alu2(5'd9, 5'd1, 5'd10); #1;
    chk_o("ldsplit_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_o("ldsplit_c1", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk_o("ldsplit_c2", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_stall("ldsplit", 3'd4);

    @(negedge clk); #1;
    chk_o("fsolo_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); flush = 1'b1; #1;
    chk_o("fsolo_flush", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); flush = 1'b0; alu1(5'd9, 5'd1, 5'd20); none2(); #1;
    chk_o("fsolo_after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("fsolo", 3'd5);

    @(negedge clk); ld1(5'd1, 5'd13); alu2(5'd1, 5'd2, 5'd13); #1;
    chk_o("samedest_a", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); alu1(5'd13, 5'd1, 5'd15); none2(); #1;
    chk_o("samedest_a_rd", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); alu1(5'd1, 5'd2, 5'd14); ld2(5'd1, 5'd14); #1;
    chk_o("samedest_b", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); alu1(5'd14, 5'd1, 5'd16); none2(); #1;
    chk_o("samedest_b_rd0", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_o("samedest_b_rd1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("samedest", 3'd6);

    @(negedge clk); ld1(5'd1, 5'd8); alu2(5'd8, 5'd1, 5'd10); #1;
    chk_o("sat_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_o("sat_c1", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_stall("sat_c1", 3'd7);
    @(negedge clk); #1;
    chk_o("sat_c2", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_stall("sat_c2", 3'd7);

    @(negedge clk); #1;
    chk_o("rst_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk_o("rst_during", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; alu1(5'd8, 5'd1, 5'd17); none2(); #1;
    chk_o("rst_after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("rst_after", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_hazard_scoreboard.md
Name: dual_issue_hazard_scoreboard

Overview:
- Issue-side partner of the dual-issue EX forwarding logic. Forwarding consumes MEM/WB destination tags; this block decides which ID-stage instructions may advance into EX.
- Tracks, per architectural register, how many cycles remain until a pending result becomes forwardable. Also detects intra-pair dependencies.
- Either dispatches both slots, splits the pair (slot1 now, slot2 a cycle later), or holds the ID stage. Sits between the IF/ID pipe register and the ID/EX pipe register.

Parameters:
- LOAD_LAT, 1, extra stall cycles a load result needs before EX forwarding can supply it.
- CNT_W, 2, width of each per-register pending counter; must hold LOAD_LAT.
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  branch/jump squash of both ID slots
- id_valid1, id_valid2  in  1 each  slot1 (older) / slot2 (younger) holds a real instruction
- rs1_id, rt1_id, rs2_id, rt2_id  in  5 each  source registers per slot
- use_rs1, use_rt1, use_rs2, use_rt2  in  1 each  source actually read
- dest1_id, dest2_id  in  5 each  destination register per slot
- regwrite1_id, regwrite2_id  in  1 each  slot writes a register
- memread1_id, memread2_id  in  1 each  slot is a load
- issue1, issue2  out  1 each  slot advances into EX this cycle (combinational)
- hold_id  out  1  freeze PC and IF/ID this cycle (combinational)
- split_active  out  1  registered; slot1 already issued, slot2 waiting
- stall_count  out  PERF_W  saturating count of cycles with hold_id=1

Behaviour:
- Reset (rst=0 at clk edge): state=PAIR, all 32 counters=0, stall_count=0. While rst=0, issue1=issue2=hold_id=0 and split_active=0.
- Register 0 is never pending. Any source of register 0 is hazard-free.
- busy(r) = cnt[r]!=0.
- hz1 = (use_rs1 & busy(rs1_id)) | (use_rt1 & busy(rt1_id)).
- sb2 = the same test on slot2 sources.
- intra = regwrite1_id & dest1_id!=0 & ((use_rs2 & rs2_id==dest1_id) | (use_rt2 & rt2_id==dest1_id)).
- State PAIR:
  - flush: issue1=issue2=0, hold_id=0.
  - !id_valid1: no issue, hold_id=0. A lone slot2 without slot1 is illegal; ignore it.
  - hz1: issue1=issue2=0, hold_id=1. Slot2 never passes slot1.
  - !hz1 & (!id_valid2 | (!sb2 & !intra)): issue1=1, issue2=id_valid2, hold_id=0.
  - !hz1 & id_valid2 & (sb2 | intra): issue1=1, issue2=0, hold_id=1, next state=SOLO2.
- State SOLO2 (split_active=1):
  - Slot1 inputs ignored; intra is not checked (the value now forwards from MEM).
  - flush: issue2=0, hold_id=0, next=PAIR.
  - sb2: hold_id=1, stay in SOLO2.
  - else: issue2=1, hold_id=0, next=PAIR.
- Counter update each edge:
  - Every nonzero counter decrements by 1.
  - Then, for each issued slot with regwrite & dest!=0: cnt[dest] <= memread ? LOAD_LAT : 0. Set overrides decrement.
  - If both slots issue to the same dest, slot2's value wins.
  - ALU results forward from MEM with no stall, so they set 0.
- flush does not clear counters; older in-flight loads stay tracked.
- stall_count increments when hold_id=1 and saturates at all-ones.
- Latency: issue decisions are same-cycle combinational from registered state/counters. Counter effects are visible the next cycle.

Test Plan:
- Independent pair: add r3,r1,r2 / sub r6,r4,r5, all counters 0 -> issue1=issue2=1, hold_id=0, state stays PAIR.
- Intra-pair RAW: add r3,r1,r2 / or r7,r3,r4 -> cycle0 issue1=1, issue2=0, hold_id=1. Cycle1 split_active=1, issue2=1, hold_id=0. stall_count=1.
- Load-use: lw r8 issued as slot1 (cnt[8]=1). Next pair reads r8 in slot1 -> one cycle issue1=0, hold_id=1, then issue1=1. Reading r8 through r0 instead -> no stall.
- Load then split: lw r9 / add r10,r9,r1 -> slot1 issues (cnt[9]=1), SOLO2 holds 1 cycle on sb2, issue2 fires the cycle after. Total hold_id cycles=2.
- Flush in SOLO2: enter SOLO2 then assert flush -> issue2=0, hold_id=0, split_active=0 next cycle. cnt of the issued load still decrements to 0.
- Reset mid-operation: rst=0 while in SOLO2 with cnt[8]=1 -> next cycle state=PAIR, all counters 0, stall_count=0, outputs 0.
